// File: rtl/zluudg_crc_arbiter_pkg.sv
// Shared types and constants for the two-port CRC engine arbiter.
// Holds the FSM state encoding and the round-robin pick helper.
package zluudg_crc_arbiter_pkg;

    localparam int unsigned N_PORTS = 2;
    localparam int unsigned MODE_W  = 32;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } arb_state_e;

    // On a tie the port that did not win last time gets the engine.
    function automatic logic pick_port(input logic [N_PORTS-1:0] req, input logic rr_last);
        if (req[0] && req[1]) begin
            return ~rr_last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/zluudg_id_fifo.sv
// Synchronous 1-bit-wide FIFO that remembers which port owns each in-flight packet.
// Simultaneous push and pop leave the count unchanged.
module zluudg_id_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     push_data_i,
    input  logic                     pop_i,
    output logic                     head_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic              mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Depth is a power of two, so the count MSB alone marks full.
    assign full_o  = count_q[PtrW];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/zluudg_crc_arbiter.sv
// Shares one CRC engine between two AXI-stream requesters, one whole packet at a time,
// and steers each engine output packet back to the requester that issued it.
module zluudg_crc_arbiter
    import zluudg_crc_arbiter_pkg::*;
#(
    parameter int unsigned ROUTE_DEPTH = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [N_PORTS*MODE_W-1:0]   sr_mode,
    input  logic [N_PORTS*DATA_W-1:0]   s_tdata,
    input  logic [N_PORTS-1:0]          s_tvalid,
    input  logic [N_PORTS-1:0]          s_tlast,
    output logic [N_PORTS-1:0]          s_tready,
    output logic [MODE_W-1:0]           crc_mode,
    output logic [DATA_W-1:0]           crc_i_tdata,
    output logic                        crc_i_tvalid,
    output logic                        crc_i_tlast,
    input  logic                        crc_i_tready,
    input  logic [DATA_W-1:0]           crc_o_tdata,
    input  logic                        crc_o_tvalid,
    input  logic                        crc_o_tlast,
    output logic                        crc_o_tready,
    output logic [N_PORTS*DATA_W-1:0]   m_tdata,
    output logic [N_PORTS-1:0]          m_tvalid,
    output logic [N_PORTS-1:0]          m_tlast,
    input  logic [N_PORTS-1:0]          m_tready,
    output logic [N_PORTS*CNT_W-1:0]    pkt_cnt
);

    localparam int unsigned CntW = $clog2(ROUTE_DEPTH) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(ROUTE_DEPTH);

    arb_state_e         state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               rr_last_q, rr_last_d;
    logic [MODE_W-1:0]  crc_mode_q, crc_mode_d;
    logic [CNT_W-1:0]   pkt_cnt0_q;
    logic [CNT_W-1:0]   pkt_cnt1_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_head;
    logic [CntW-1:0]    fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic [MODE_W-1:0]  mode_arr [N_PORTS];
    logic [DATA_W-1:0]  s_data   [N_PORTS];

    for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
        assign mode_arr[p] = sr_mode[p*MODE_W +: MODE_W];
        assign s_data[p]   = s_tdata[p*DATA_W +: DATA_W];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            rr_last_q  <= 1'b1;
            crc_mode_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_last_q  <= rr_last_d;
            crc_mode_q <= crc_mode_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_last_d    = rr_last_q;
        crc_mode_d   = crc_mode_q;
        fifo_push    = 1'b0;
        s_tready     = '0;
        crc_i_tdata  = s_data[gnt_q];
        crc_i_tvalid = 1'b0;
        crc_i_tlast  = 1'b0;

        case (state_q)
            StIdle: begin
                // The decision cycle is the single bubble each packet pays.
                if ((fifo_count < DepthCnt) && (s_tvalid != '0)) begin
                    gnt_d      = pick_port(s_tvalid, rr_last_q);
                    crc_mode_d = mode_arr[gnt_d];
                    rr_last_d  = gnt_d;
                    fifo_push  = 1'b1;
                    state_d    = StActive;
                end
            end
            StActive: begin
                crc_i_tvalid    = s_tvalid[gnt_q];
                crc_i_tlast     = s_tlast[gnt_q];
                s_tready[gnt_q] = crc_i_tready;
                if (s_tvalid[gnt_q] && crc_i_tready && s_tlast[gnt_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (areset) begin
            fifo_push    = 1'b0;
            s_tready     = '0;
            crc_i_tvalid = 1'b0;
        end
    end

    // Return path follows the route FIFO head, independent of the request FSM.
    always_comb begin
        m_tdata      = {N_PORTS{crc_o_tdata}};
        m_tvalid     = '0;
        m_tlast      = '0;
        crc_o_tready = 1'b0;
        if (!fifo_empty && !areset) begin
            m_tvalid[fifo_head] = crc_o_tvalid;
            m_tlast[fifo_head]  = crc_o_tlast;
            crc_o_tready        = m_tready[fifo_head];
        end
    end

    assign fifo_pop = crc_o_tvalid && crc_o_tready && crc_o_tlast;

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else if (fifo_pop) begin
            if (fifo_head) begin
                pkt_cnt1_q <= pkt_cnt1_q + CNT_W'(1);
            end else begin
                pkt_cnt0_q <= pkt_cnt0_q + CNT_W'(1);
            end
        end
    end

    zluudg_id_fifo #(
        .Depth(ROUTE_DEPTH)
    ) u_route_fifo (
        .clk_i      (aclk),
        .rst_i      (areset),
        .push_i     (fifo_push),
        .push_data_i(gnt_d),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    a_no_push_when_full: assert property (@(posedge aclk) disable iff (areset)
        !(fifo_push && fifo_full));

    assign crc_mode = crc_mode_q;
    assign pkt_cnt  = {pkt_cnt1_q, pkt_cnt0_q};

endmodule

// File: tb/tb_zluudg_crc_arbiter.sv
// Bench for zluudg_crc_arbiter: queue-based requesters, a pass-through engine model
// and a scoreboard that follows every beat from requester to its return port.
module tb_zluudg_crc_arbiter;

    localparam logic [31:0] OUT_XOR = 32'h5A5A_0F0F;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [63:0] sr_mode = '0;
    logic [63:0] s_tdata = '0;
    logic [1:0]  s_tvalid = '0;
    logic [1:0]  s_tlast = '0;
    logic [1:0]  s_tready;
    logic [31:0] crc_mode;
    logic [31:0] crc_i_tdata;
    logic        crc_i_tvalid;
    logic        crc_i_tlast;
    logic        crc_i_tready = 1'b1;
    logic [31:0] crc_o_tdata = '0;
    logic        crc_o_tvalid = 1'b0;
    logic        crc_o_tlast = 1'b0;
    logic        crc_o_tready;
    logic [63:0] m_tdata;
    logic [1:0]  m_tvalid;
    logic [1:0]  m_tlast;
    logic [1:0]  m_tready = 2'b11;
    logic [31:0] pkt_cnt;

    zluudg_crc_arbiter #(
        .ROUTE_DEPTH(4),
        .CNT_W      (16)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .sr_mode     (sr_mode),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .crc_mode    (crc_mode),
        .crc_i_tdata (crc_i_tdata),
        .crc_i_tvalid(crc_i_tvalid),
        .crc_i_tlast (crc_i_tlast),
        .crc_i_tready(crc_i_tready),
        .crc_o_tdata (crc_o_tdata),
        .crc_o_tvalid(crc_o_tvalid),
        .crc_o_tlast (crc_o_tlast),
        .crc_o_tready(crc_o_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .pkt_cnt     (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // Requester queues hold {last, data}; engine queue holds {src, last, data}.
    logic [32:0] req0_q [$];
    logic [32:0] req1_q [$];
    logic [33:0] eng_q [$];
    logic [31:0] mode_log [$];
    int          grant_log [$];
    int          grant_cyc [$];
    int          last_cyc [$];
    int          out_log [$];
    int          out_cyc [$];
    logic [15:0] exp_cnt [2];
    logic [1:0]  in_mid = '0;
    int          cyc = 0;

    logic        rand_rdy = 1'b0;
    logic        chk_mode = 1'b1;
    logic        ci_rdy_fix = 1'b1;
    logic [1:0]  m_rdy_fix = 2'b11;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Requester, engine and sink models: drive on the falling edge, score 1 time unit later.
    logic [1:0]  s_hs;
    logic        ci_hs;
    logic [32:0] head;
    logic [33:0] ent;
    logic        src;
    int          p;
    initial begin
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        forever begin
            @(negedge aclk);
            cyc++;
            s_tvalid[0] = (req0_q.size() != 0);
            s_tlast[0]  = 1'b0;
            if (req0_q.size() != 0) begin
                s_tdata[31:0] = req0_q[0][31:0];
                s_tlast[0]    = req0_q[0][32];
            end
            s_tvalid[1] = (req1_q.size() != 0);
            s_tlast[1]  = 1'b0;
            if (req1_q.size() != 0) begin
                s_tdata[63:32] = req1_q[0][31:0];
                s_tlast[1]     = req1_q[0][32];
            end
            crc_o_tvalid = (eng_q.size() != 0);
            crc_o_tlast  = 1'b0;
            if (eng_q.size() != 0) begin
                crc_o_tdata = eng_q[0][31:0] ^ OUT_XOR;
                crc_o_tlast = eng_q[0][32];
            end
            if (rand_rdy) begin
                m_tready     = 2'($urandom_range(0, 3));
                crc_i_tready = 1'($urandom_range(0, 1));
            end else begin
                m_tready     = m_rdy_fix;
                crc_i_tready = ci_rdy_fix;
            end
            #1;
            if (areset) begin
                req0_q.delete();
                req1_q.delete();
                eng_q.delete();
                in_mid     = '0;
                exp_cnt[0] = '0;
                exp_cnt[1] = '0;
            end else begin
                if (eng_q.size() != 0) begin
                    ent = eng_q[0];
                    src = ent[33];
                    check("m_tvalid_route", m_tvalid, src ? 2'b10 : 2'b01);
                    check("m_tdata", src ? m_tdata[63:32] : m_tdata[31:0], ent[31:0] ^ OUT_XOR);
                    check("m_tlast", m_tlast[src], ent[32]);
                    check("crc_o_tready", crc_o_tready, m_tready[src]);
                    if (crc_o_tready) begin
                        void'(eng_q.pop_front());
                        if (ent[32]) begin
                            exp_cnt[src] = exp_cnt[src] + 16'd1;
                            out_log.push_back(int'(src));
                            out_cyc.push_back(cyc);
                        end
                    end
                end else begin
                    check("m_tvalid_idle", m_tvalid, 2'b00);
                end
                s_hs  = s_tvalid & s_tready;
                ci_hs = crc_i_tvalid && crc_i_tready;
                check("s_tready_onehot", ($countones(s_tready) <= 1), 1'b1);
                if (ci_hs || (s_hs != 2'b00)) begin
                    check("in_handshake", {ci_hs, 2'($countones(s_hs))}, {1'b1, 2'd1});
                    if (s_hs != 2'b00) begin
                        p = s_hs[1] ? 1 : 0;
                        if (in_mid != 2'b00) check("in_port_hold", p, in_mid[1] ? 1 : 0);
                        head = (p == 1) ? req1_q[0] : req0_q[0];
                        check("crc_i_tdata", crc_i_tdata, head[31:0]);
                        check("crc_i_tlast", crc_i_tlast, head[32]);
                        if (chk_mode) begin
                            check("crc_mode_beat", crc_mode, (p == 1) ? sr_mode[63:32] : sr_mode[31:0]);
                        end
                        mode_log.push_back(crc_mode);
                        if (!in_mid[p]) begin
                            grant_log.push_back(p);
                            grant_cyc.push_back(cyc);
                        end
                        in_mid[p] = !head[32];
                        if (head[32]) last_cyc.push_back(cyc);
                        eng_q.push_back({p[0], head});
                        if (p == 1) void'(req1_q.pop_front());
                        else void'(req0_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic clear_logs();
        mode_log.delete();
        grant_log.delete();
        grant_cyc.delete();
        last_cyc.delete();
        out_log.delete();
        out_cyc.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((req0_q.size() + req1_q.size() + eng_q.size()) != 0 && n < budget) begin
            tick(1);
            n++;
        end
        tick(2);
        check({tag, "_drained"}, (n < budget), 1'b1);
    endtask

    task automatic push_pkt(input int port, input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) begin
            if (port == 1) req1_q.push_back({(i == len - 1), base + 32'(i) * 32'h11});
            else req0_q.push_back({(i == len - 1), base + 32'(i) * 32'h11});
        end
    endtask

    initial begin
        int n;
        int cnt_push [2];
        int cnt_out [2];

        // Reset state
        tick(3);
        check("rst_s_tready", s_tready, 2'b00);
        check("rst_m_tvalid", m_tvalid, 2'b00);
        check("rst_crc_i_tvalid", crc_i_tvalid, 1'b0);
        check("rst_crc_o_tready", crc_o_tready, 1'b0);
        check("rst_crc_mode", crc_mode, 32'h0);
        check("rst_pkt_cnt", pkt_cnt, 32'h0);
        check("rst_rr_last", dut.rr_last_q, 1'b1);
        areset = 1'b0;
        tick(1);

        // Single 3-beat packet from port0
        sr_mode[31:0] = 32'd1;
        clear_logs();
        push_pkt(0, 3, 32'h11);
        wait_idle("single", 100);
        check("single_beats", mode_log.size(), 3);
        check("single_mode_first_beat", mode_log[0], 32'd1);
        check("single_out_port", out_log[0], 0);
        check("single_cnt0", pkt_cnt[15:0], 16'd1);
        check("single_cnt1", pkt_cnt[31:16], 16'd0);

        // Tie right after reset: port0 first, one bubble, then port1
        areset = 1'b1;
        tick(2);
        areset = 1'b0;
        clear_logs();
        push_pkt(0, 2, 32'hA000_0001);
        push_pkt(1, 2, 32'hB000_0001);
        wait_idle("tie", 100);
        check("tie_grants", grant_log.size(), 2);
        check("tie_first", grant_log[0], 0);
        check("tie_second", grant_log[1], 1);
        check("tie_bubble", grant_cyc[1] - last_cyc[0], 2);
        check("tie_out_order", {out_log[0][0], out_log[1][0]}, 2'b01);
        check("tie_rr_last", dut.rr_last_q, 1'b1);
        check("tie_cnt", pkt_cnt, {16'd1, 16'd1});

        // Output backpressure fills the route FIFO
        clear_logs();
        m_rdy_fix = 2'b00;
        for (int i = 0; i < 5; i++) push_pkt(1, 1, 32'hC000_0000 + 32'(i));
        tick(20);
        check("bp_grants_held", grant_log.size(), 4);
        check("bp_s_tready1", s_tready[1], 1'b0);
        check("bp_pending", req1_q.size(), 1);
        m_rdy_fix = 2'b10;
        wait_idle("bp", 200);
        check("bp_grants_all", grant_log.size(), 5);
        check("bp_outs", out_log.size(), 5);
        check("bp_5th_after_pop", grant_cyc[4] - out_cyc[0], 2);
        check("bp_cnt1", pkt_cnt[31:16], exp_cnt[1]);
        check("bp_cnt1_abs", pkt_cnt[31:16], 16'd6);
        m_rdy_fix = 2'b11;

        // Mode change mid-packet only takes effect at the next grant
        clear_logs();
        chk_mode = 1'b0;
        sr_mode[31:0] = 32'd1;
        push_pkt(0, 4, 32'hD000_0000);
        n = 0;
        while (mode_log.size() < 2 && n < 50) begin
            tick(1);
            n++;
        end
        check("mh_reach_beat2", (n < 50), 1'b1);
        sr_mode[31:0] = 32'd2;
        wait_idle("mh_a", 100);
        push_pkt(0, 1, 32'hD100_0000);
        wait_idle("mh_b", 100);
        check("mh_beats", mode_log.size(), 5);
        for (int i = 0; i < 4; i++) check("mh_hold", mode_log[i], 32'd1);
        check("mh_next", mode_log[4], 32'd2);
        check("mh_crc_mode", crc_mode, 32'd2);
        chk_mode = 1'b1;

        // Reset in the middle of a packet
        clear_logs();
        push_pkt(0, 4, 32'hE000_0000);
        n = 0;
        while (mode_log.size() < 2 && n < 50) begin
            tick(1);
            n++;
        end
        check("rm_reach_beat2", (n < 50), 1'b1);
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
        check("rm_s_tready", s_tready, 2'b00);
        check("rm_m_tvalid", m_tvalid, 2'b00);
        check("rm_crc_i_tvalid", crc_i_tvalid, 1'b0);
        check("rm_fifo_empty", crc_o_tready, 1'b0);
        check("rm_pkt_cnt", pkt_cnt, 32'h0);
        clear_logs();
        push_pkt(0, 2, 32'hE100_0000);
        wait_idle("rm_fresh", 100);
        check("rm_fresh_grant", grant_log.size(), 1);
        check("rm_fresh_cnt0", pkt_cnt[15:0], 16'd1);

        // Counter wrap on port1
        force dut.pkt_cnt1_q = 16'hFFFF;
        #1;
        release dut.pkt_cnt1_q;
        exp_cnt[1] = 16'hFFFF;
        push_pkt(1, 2, 32'hF000_0000);
        wait_idle("wrap", 100);
        check("wrap_cnt1", pkt_cnt[31:16], 16'h0000);
        check("wrap_cnt1_model", pkt_cnt[31:16], exp_cnt[1]);
        check("wrap_cnt0", pkt_cnt[15:0], 16'd1);

        // Random traffic with random readiness on both sides
        clear_logs();
        sr_mode = {$urandom(), $urandom()};
        rand_rdy = 1'b1;
        cnt_push[0] = 0;
        cnt_push[1] = 0;
        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(0, 1));
            push_pkt(n, int'($urandom_range(1, 4)), $urandom());
            cnt_push[n]++;
        end
        wait_idle("rand", 5000);
        rand_rdy = 1'b0;
        cnt_out[0] = 0;
        cnt_out[1] = 0;
        foreach (out_log[i]) cnt_out[out_log[i]]++;
        check("rand_out0", cnt_out[0], cnt_push[0]);
        check("rand_out1", cnt_out[1], cnt_push[1]);
        check("rand_cnt0", pkt_cnt[15:0], exp_cnt[0]);
        check("rand_cnt1", pkt_cnt[31:16], exp_cnt[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
